// File: rtl/contador_mod_n_if.sv
// Bus bundle for contador_mod_n: control/load inputs from the user (master),
// count value and status flags back from the counter (slave).
interface contador_mod_n_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             co;
  logic             wrapped;
  logic             load_err;

  modport master (
    output en, up, load, d, sat,
    input  q, tc, co, wrapped, load_err
  );

  modport slave (
    input  en, up, load, d, sat,
    output q, tc, co, wrapped, load_err
  );
endinterface

// File: rtl/contador_mod_n.sv
// Synchronous modulo-N up/down counter with range-checked load, wrap/saturate
// mode and a combinational carry for cascading stages on a common clock.
module contador_mod_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 8
) (
  input logic             clk,
  input logic             clr,
  contador_mod_n_if.slave bus
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("contador_mod_n: MODULUS %0d outside 2..2**%0d", MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             wrapped_r;
  logic             load_err_r;
  logic             in_range;

  assign in_range = {1'b0, bus.d} < MOD_EXT;

  // Terminal count follows the live direction input, so it flips the same cycle up does.
  assign bus.tc = bus.up ? (q_r == LAST) : (q_r == '0);

  // A wrap edge is exactly the condition for carrying into the next stage.
  assign bus.co = bus.en & bus.tc & ~bus.sat & ~bus.load & ~clr;

  always_comb begin
    // NOTE: hold is assigned first so every path drives q_next and no latch is inferred.
    q_next = q_r;
    if (bus.load) begin
      q_next = in_range ? bus.d : '0;
    end else if (bus.en) begin
      if (!bus.tc) begin
        q_next = bus.up ? q_r + 1'b1 : q_r - 1'b1;
      end else if (!bus.sat) begin
        q_next = bus.up ? '0 : LAST;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (clr) begin
      q_r        <= '0;
      wrapped_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_next;
      wrapped_r  <= bus.co;
      load_err_r <= bus.load & ~in_range;
    end
  end

  assign bus.q        = q_r;
  assign bus.wrapped  = wrapped_r;
  assign bus.load_err = load_err_r;

endmodule
